// File: rtl/seq_det_param_if.sv
// Signal bundle for seq_det_param: serial input, pattern-load controls and detector status.
// The bench drives through the master modport; the detector attaches through the slave modport.
interface seq_det_param_if #(
    parameter int PAT_LEN = 7,
    parameter int CNT_W   = 8
);
    localparam int FILL_W = $clog2(PAT_LEN + 1);

    logic               in;
    logic               in_valid;
    logic               load;
    logic [PAT_LEN-1:0] pattern;
    logic               mode_overlap;
    logic               cnt_clr;
    logic               out;
    logic [CNT_W-1:0]   match_cnt;
    logic [FILL_W-1:0]  fill;

    modport master (
        output in, in_valid, load, pattern, mode_overlap, cnt_clr,
        input  out, match_cnt, fill
    );

    modport slave (
        input  in, in_valid, load, pattern, mode_overlap, cnt_clr,
        output out, match_cnt, fill
    );
endinterface

// File: rtl/seq_det_param.sv
// Serial pattern detector with run-time pattern load, overlap/non-overlap mode,
// a registered one-cycle match pulse and a saturating match counter.
module seq_det_param #(
    parameter int               PAT_LEN  = 7,
    parameter logic [PAT_LEN-1:0] PAT_INIT = 7'b1110010,
    parameter int               CNT_W    = 8
) (
    input  logic           clk,
    input  logic           reset,
    seq_det_param_if.slave bus
);
    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_NEAR = FILL_W'(PAT_LEN - 1);

    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic [PAT_LEN-1:0] pat_q, pat_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_base;
    logic               out_q, out_d;
    logic [PAT_LEN-1:0] window;
    logic               hit;

    // The current bit completes the window, so history only needs PAT_LEN-1 bits.
    assign window = {hist_q, bus.in};

    always_comb begin
        hist_d   = hist_q;
        pat_d    = pat_q;
        fill_d   = fill_q;
        out_d    = 1'b0;
        hit      = 1'b0;
        cnt_base = bus.cnt_clr ? '0 : cnt_q;

        if (bus.load) begin
            pat_d  = bus.pattern;
            hist_d = '0;
            fill_d = '0;
        end else if (bus.in_valid) begin
            hist_d = window[PAT_LEN-2:0];
            hit    = (fill_q >= FILL_NEAR) && (window == pat_q);
            out_d  = hit;
            if (hit) begin
                // Non-overlap discards the bits consumed by this hit.
                fill_d = bus.mode_overlap ? FILL_MAX : '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end

        cnt_d = cnt_base;
        if (hit && (cnt_base != {CNT_W{1'b1}})) begin
            cnt_d = cnt_base + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '0;
            pat_q  <= PAT_INIT;
            fill_q <= '0;
            cnt_q  <= '0;
            out_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            pat_q  <= pat_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.match_cnt = cnt_q;
    assign bus.fill      = fill_q;
endmodule

// File: tb/tb_seq_det_param.sv
// Directed bench for seq_det_param: a vector table for the main scenarios plus
// hand-written sequences for idle gaps, counter saturation and pattern-free streams.
module tb_seq_det_param;
    logic       clk = 1'b0;
    logic       reset;
    logic       s_in, s_valid, s_load, s_mode, s_clr;
    logic [6:0] s_pat;

    int n_tests = 0;
    int n_fail  = 0;

    seq_det_param_if #(.PAT_LEN(7), .CNT_W(8)) bus_a ();
    seq_det_param_if #(.PAT_LEN(7), .CNT_W(2)) bus_b ();

    assign bus_a.in = s_in;   assign bus_a.in_valid = s_valid; assign bus_a.load = s_load;
    assign bus_a.pattern = s_pat; assign bus_a.mode_overlap = s_mode; assign bus_a.cnt_clr = s_clr;
    assign bus_b.in = s_in;   assign bus_b.in_valid = s_valid; assign bus_b.load = s_load;
    assign bus_b.pattern = s_pat; assign bus_b.mode_overlap = s_mode; assign bus_b.cnt_clr = s_clr;

    seq_det_param #(.PAT_LEN(7), .PAT_INIT(7'b1110010), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .bus(bus_a.slave)
    );
    seq_det_param #(.PAT_LEN(7), .PAT_INIT(7'b1110010), .CNT_W(2)) u_dut_small (
        .clk(clk), .reset(reset), .bus(bus_b.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, ld, v, i, mode, clr;
        logic [6:0] pat;
        logic       exp_out;
        logic [7:0] exp_cnt;
        logic [2:0] exp_fill;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, ld, input logic [6:0] pat,
                                input logic v, i, mode, clr,
                                input logic eo, input logic [7:0] ec, input logic [2:0] ef);
        vec_t t;
        t.rst = rst; t.ld = ld; t.pat = pat; t.v = v; t.i = i; t.mode = mode; t.clr = clr;
        t.exp_out = eo; t.exp_cnt = ec; t.exp_fill = ef;
        vecs.push_back(t);
    endfunction

    function automatic void check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endfunction

    // Drive one edge's inputs, then sample 1 time unit after the edge.
    task automatic step(input logic rst, ld, input logic [6:0] pat,
                        input logic v, i, mode, clr);
        reset = rst; s_load = ld; s_pat = pat; s_valid = v; s_in = i; s_mode = mode; s_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string tag, input logic eo, input int ec, input int ef);
        check({tag, " out"},  int'(bus_a.out), int'(eo));
        check({tag, " cnt"},  int'(bus_a.match_cnt), ec);
        check({tag, " fill"}, int'(bus_a.fill), ef);
    endtask

    task automatic feed_bit(input logic b, input logic clr);
        step(1'b0, 1'b0, 7'd0, 1'b1, b, 1'b1, clr);
    endtask

    logic [6:0] p_def;
    logic [6:0] p_alt;

    initial begin
        int k, fill_m, ones_run, cnt_m;
        logic b;

        reset = 1'b1; s_in = 0; s_valid = 0; s_load = 0; s_pat = 0; s_mode = 1; s_clr = 0;
        p_def = 7'b1110010;
        p_alt = 7'b1010101;

        // Default pattern in overlap mode, then cnt_clr alone.
        add(1,0,0, 0,0,1,0, 0,0,0);
        add(0,0,0, 1,1,1,0, 0,0,1); add(0,0,0, 1,1,1,0, 0,0,2); add(0,0,0, 1,1,1,0, 0,0,3);
        add(0,0,0, 1,0,1,0, 0,0,4); add(0,0,0, 1,0,1,0, 0,0,5); add(0,0,0, 1,1,1,0, 0,0,6);
        add(0,0,0, 1,0,1,0, 1,1,7);
        add(0,0,0, 0,0,1,0, 0,1,7);
        add(0,0,0, 0,0,1,1, 0,0,7);
        // Pattern 1010101, overlap: hits after bits 7 and 9.
        add(0,1,p_alt, 0,0,1,1, 0,0,0);
        for (int j = 0; j < 9; j++)
            add(0,0,0, 1,(j % 2 == 0),1,0, (j == 6 || j == 8),
                (j < 6) ? 0 : ((j < 8) ? 1 : 2), (j < 6) ? j + 1 : 7);
        // Same stream, non-overlap: single hit, fill restarts.
        add(0,1,p_alt, 0,0,0,1, 0,0,0);
        for (int j = 0; j < 9; j++)
            add(0,0,0, 1,(j % 2 == 0),0,0, (j == 6), (j < 6) ? 0 : 1,
                (j < 6) ? j + 1 : j - 6);
        // Reset mid-sequence discards history; reset also overrides a load.
        add(1,0,0, 0,0,1,0, 0,0,0);
        add(0,0,0, 1,1,1,0, 0,0,1); add(0,0,0, 1,1,1,0, 0,0,2); add(0,0,0, 1,1,1,0, 0,0,3);
        add(0,0,0, 1,0,1,0, 0,0,4); add(0,0,0, 1,0,1,0, 0,0,5); add(0,0,0, 1,1,1,0, 0,0,6);
        add(1,1,7'b0000001, 1,1,1,0, 0,0,0);
        add(0,0,0, 1,0,1,0, 0,0,1);
        // Load mid-sequence with in_valid high: bit ignored, new pattern active.
        add(0,0,0, 1,1,1,0, 0,0,2); add(0,0,0, 1,1,1,0, 0,0,3); add(0,0,0, 1,0,1,0, 0,0,4);
        add(0,0,0, 1,0,1,0, 0,0,5); add(0,0,0, 1,1,1,0, 0,0,6);
        add(0,1,7'b0000001, 1,1,1,0, 0,0,0);
        add(0,0,0, 1,0,1,0, 0,0,1);
        for (int j = 0; j < 5; j++) add(0,0,0, 1,0,1,0, 0,0,j + 2);
        add(0,0,0, 1,1,1,0, 1,1,7);

        foreach (vecs[n]) begin
            step(vecs[n].rst, vecs[n].ld, vecs[n].pat, vecs[n].v, vecs[n].i, vecs[n].mode, vecs[n].clr);
            check_main($sformatf("vec%0d", n), vecs[n].exp_out, int'(vecs[n].exp_cnt),
                       int'(vecs[n].exp_fill));
        end

        // Idle gaps of 0..3 cycles between bits must not break the match.
        step(1,0,0, 0,0,1,0);
        fill_m = 0;
        for (int j = 0; j < 7; j++) begin
            b = p_def[6 - j];
            feed_bit(b, 1'b0);
            fill_m++;
            check_main($sformatf("gap_bit%0d", j), (j == 6), (j == 6) ? 1 : 0, fill_m);
            for (int g = 0; g < (j % 4); g++) begin
                step(0,0,0, 0,0,1,0);
                check_main($sformatf("gap_idle%0d_%0d", j, g), 1'b0, (j == 6) ? 1 : 0, fill_m);
            end
        end

        // Saturation of the 2-bit counter; cnt_clr on the 6th hit gives 1.
        step(1,0,0, 0,0,1,0);
        for (int h = 1; h <= 6; h++) begin
            for (int j = 0; j < 7; j++) feed_bit(p_def[6 - j], (h == 6 && j == 6));
            check($sformatf("sat_hit%0d out", h), int'(bus_b.out), 1);
            check($sformatf("sat_hit%0d small_cnt", h), int'(bus_b.match_cnt),
                  (h == 6) ? 1 : ((h > 3) ? 3 : h));
            check($sformatf("sat_hit%0d main_cnt", h), int'(bus_a.match_cnt), (h == 6) ? 1 : h);
        end

        // 20 random bits with no run of three ones can never contain 1110010.
        step(1,0,0, 0,0,1,0);
        ones_run = 0; cnt_m = 0;
        for (int j = 0; j < 20; j++) begin
            b = (ones_run == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            ones_run = b ? ones_run + 1 : 0;
            feed_bit(b, 1'b0);
            k = (j + 1 > 7) ? 7 : j + 1;
            check_main($sformatf("rnd%0d", j), 1'b0, cnt_m, k);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_det_param.md
# seq_det_param

Parametrised serial pattern detector for the FSM sequence-detector family. It watches a 1-bit input stream qualified by a valid strobe and compares the last `PAT_LEN` accepted bits against a run-time-loadable pattern. On a hit it raises a one-cycle registered match pulse and increments a saturating match counter. Overlapping or non-overlapping matching is selectable at run time, and the block exposes its progress count so it can be observed next to the fixed-pattern detectors.

## Interface
Parameters:
- `PAT_LEN`, 7: pattern length in bits; legal range ≥ 2.
- `PAT_INIT`, 7'b1110010: pattern in force after reset. The MSB is the first bit received.
- `CNT_W`, 8: width of the match counter.

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: reset is synchronous and active-high.
- `in` input 1: serial data bit.
- `in_valid` input 1: `in` is accepted on an edge where this is 1.
- `load` input 1: latch `pattern` and restart the detector.
- `pattern` input `PAT_LEN`: new pattern, sampled only when `load`=1.
- `mode_overlap` input 1: 1 selects overlapping matches, 0 selects non-overlapping.
- `cnt_clr` input 1: clear the match counter.
- `out` output 1: match pulse, registered.
- `match_cnt` output `CNT_W`: number of matches, saturating.
- `fill` output `$clog2(PAT_LEN+1)`: number of accepted bits in the current window, 0..`PAT_LEN`.

## Operation
- Internal registers:
  - `hist[PAT_LEN-2:0]` holds accepted-bit history.
  - `pat_q[PAT_LEN-1:0]` holds the active pattern.
  - `fill` holds the progress count.
  - `match_cnt` holds the match count.
  - `out` holds the match pulse.
- Window is `{hist, in}`, with the newest bit in the LSB.
- Priority on each edge: `reset` > `load` > `in_valid`.
- `reset`=1:
  - `hist`=0, `fill`=0, `out`=0, `match_cnt`=0, `pat_q`=`PAT_INIT`.
  - This happens regardless of any other input.
- `load`=1 (and no reset):
  - `pat_q`=`pattern`, `hist`=0, `fill`=0, `out`=0.
  - `in_valid` is ignored on this edge.
  - `match_cnt` is unchanged unless `cnt_clr`=1.
- `in_valid`=1 (no reset, no load):
  - `hist` shifts left and takes in `in`.
  - hit = (`fill` ≥ `PAT_LEN`-1) AND (`{hist, in}` == `pat_q`).
  - On a hit: `out`=1; `fill` becomes `PAT_LEN` if `mode_overlap`=1, or 0 if `mode_overlap`=0. Bits before the hit are then unusable.
  - On no hit: `out`=0 and `fill` = min(`fill`+1, `PAT_LEN`).
- `in_valid`=0: `out`=0; `hist` and `fill` hold.
- `match_cnt` behaviour:
  - `cnt_clr` alone sets it to 0.
  - A hit increments it, saturating at 2^`CNT_W`-1 with no wrap.
  - `cnt_clr` together with a hit gives 1.
  - `cnt_clr` is honoured during `load` but not during `reset` (reset already clears it).
- `mode_overlap` is sampled on every edge; changing it mid-stream affects only the next hit.
- `hist` holds `PAT_LEN`-1 bits because the current `in` completes the window.

## Timing
- Reset values: `out`=0, `match_cnt`=0, `fill`=0.
- Latency: `out` is high for exactly one cycle, on the cycle after the edge that accepted the final pattern bit. `match_cnt` shows the new value in that same cycle.
- Back-to-back hits are possible in overlap mode with one-bit spacing, provided the pattern allows it. Each hit gives its own pulse, and `out` may stay high over consecutive cycles.
- Gaps in `in_valid` of any length do not break a match in progress.
- `load` takes effect on the following cycle. The earliest hit under the new pattern comes `PAT_LEN` accepted bits after the load edge.
- `reset` mid-sequence discards all history; `out` is never asserted on the edge after reset.

## Test plan
- Reset, default pattern, feed 1,1,1,0,0,1,0 with `in_valid`=1 → `out`=1 for one cycle after the 7th bit, `match_cnt`=1, `fill`=7 (overlap mode).
- Load 7'b1010101; stream 1,0,1,0,1,0,1,0,1:
  - `mode_overlap`=1 → hits after bits 7 and 9, `match_cnt`=2.
  - `mode_overlap`=0 → hit after bit 7 only, `match_cnt`=1, `fill`=2 at the end.
- Default pattern with 0–3 idle cycles (`in_valid`=0) between each bit → single hit, `match_cnt`=1; `out` is low during idle cycles.
- Feed 1,1,1,0,0,1, pulse `reset` for 1 cycle, then feed 0 → no hit, `fill`=1, `match_cnt`=0. Repeat with `load` in place of `reset` → same result, `pat_q` updated.
- `CNT_W`=2 instance, 5 hits → `match_cnt` sticks at 3. `cnt_clr` on the same edge as the 6th hit → `match_cnt`=1.
- Stream of 20 random bits with no occurrence of the pattern → `out` never asserts; `fill` saturates at 7.
